contador_ad_mod_2dig: RTL and testbench
=======================================

// Module: contador_AD_mod_2dig
// PURPOSE
// - Parametrised edge-triggered up/down counter with a configurable range and a registered
//   2-digit BCD output. Generic time-field counter for the clock/alarm datapath (hours 0-23,
//   min/sec 0-59, day 1-31, month 1-12).
// - Sits between the push-button/FSM control logic (enUP/enDOWN/load) and the display mux.
// - Adds over the fixed 0-23 counter: range parameters, wrap or saturate mode, synchronous
//   load, carry/borrow ticks, load-error flag.
// PARAMETERS
// - N        5    count register width in bits; must hold MOD_MAX; MOD_MAX <= 99
// - MOD_MIN  0    lowest legal count value
// - MOD_MAX  23   highest legal count value (MOD_MIN < MOD_MAX)
// - WRAP     1    1: wrap at the range ends; 0: saturate at the range ends
// PORTS
// - clk       in   1  system clock, all logic on the rising edge
// - reset     in   1  asynchronous, active-low reset
// - enUP      in   1  level request to increment; acted on at its rising edge only
// - enDOWN    in   1  level request to decrement; acted on at its rising edge only
// - load      in   1  synchronous load strobe, active high, level-sampled
// - load_val  in   N  value loaded when load=1
// - count     out  N  current count, registered
// - carry     out  1  one-cycle pulse: increment wrapped MOD_MAX->MOD_MIN
// - borrow    out  1  one-cycle pulse: decrement wrapped MOD_MIN->MOD_MAX
// - load_err  out  1  one-cycle pulse: load_val out of [MOD_MIN,MOD_MAX]; load ignored
// - digit1    out  4  BCD tens of count, registered
// - digit0    out  4  BCD units of count, registered
// BEHAVIOUR
// - Reset (reset=0, async): count=MOD_MIN; digit1/digit0=BCD(MOD_MIN); carry=borrow=load_err=0.
//   The enUP/enDOWN edge registers reset to 1, so an input held high at reset release gives no tick.
// - Edge detect: up_tick = enUP & ~enUP_q; dn_tick = enDOWN & ~enDOWN_q (1 flop each).
// - Priority per cycle: load > (up_tick & dn_tick) > up_tick > dn_tick > hold.
// - load, in range: count<=load_val. Out of range: count holds, load_err=1. Ticks in the same
//   cycle are dropped.
// - up_tick & dn_tick in the same cycle: count holds, no carry/borrow.
// - up_tick: count<MOD_MAX -> count+1. count==MOD_MAX -> WRAP=1: MOD_MIN with carry=1;
//   WRAP=0: hold, no carry.
// - dn_tick: count>MOD_MIN -> count-1. count==MOD_MIN -> WRAP=1: MOD_MAX with borrow=1;
//   WRAP=0: hold, no borrow.
// - Wrap happens only on a tick. A held count at MOD_MAX or MOD_MIN never moves by itself.
// - Latency: input edge at cycle k -> count updated at k+1 -> digits updated at k+2.
//   carry/borrow/load_err are asserted in the cycle count updates (k+1) and last one cycle.
// - Arithmetic is N bits and unsigned. Range checks are done before +/-1, so N-bit overflow
//   cannot occur.
// - BCD: digit1 = count/10, digit0 = count%10. Uses a compare-subtract chain (no divider).
//   Result registered.
// - Illegal count (unreachable; SEU/X): next tick or load restores a legal value; digits show 0,0.
// - Reset asserted mid-operation: immediate return to reset values; any pending tick is lost.
// STRUCTURE
// - Shared header contador_defs.vh holds:
//   - f_bin2bcd2 (N-bit value -> {tens,units}) function;
//   - range-check macro;
//   - standard MOD constants: HH=23, MM_SS=59, DD=31, MES=12.
// - Sub-module detector_flanco (clk, reset, in, tick). Instantiated twice for enUP/enDOWN;
//   reset value of its flop is 1.
// - Top holds the next-state logic, count register, pulse register and BCD output register.
// TESTING
// - Default params; reset; 24 enUP pulses -> count 1..23 then 0; carry=1 only on the 23->0 cycle;
//   digits 2,3 then 0,0.
// - count=0; one enDOWN pulse -> count=23, borrow=1 for 1 cycle; digit1=2, digit0=3 one cycle later.
// - WRAP=0, MOD_MIN=1, MOD_MAX=12: up from 12 -> stays 12, carry=0; down from 1 -> stays 1, borrow=0.
// - load=1 with load_val=17 -> count=17, digits 1,7. load_val=30 -> count unchanged, load_err=1
//   for 1 cycle.
// - enUP and enDOWN rising in the same cycle at count=5 -> count stays 5. enUP held high for
//   10 cycles -> exactly +1.
// - enUP held high through reset release -> no increment. Reset asserted mid-count at 14 ->
//   count=0 asynchronously, pulses 0.

Source files
------------

// File: rtl/contador_ad_mod_2dig_pkg.sv
// Shared helpers for the time-field counters: standard ranges, range check, binary->BCD.
// Pure functions and constants; no latency, no flow control.
package contador_ad_mod_2dig_pkg;

    localparam int unsigned MOD_HH    = 23;
    localparam int unsigned MOD_MM_SS = 59;
    localparam int unsigned MOD_DD    = 31;
    localparam int unsigned MOD_MES   = 12;

    function automatic logic f_in_range(input int unsigned v,
                                        input int unsigned lo,
                                        input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Compare-subtract chain, valid for 0..99; returns {tens, units}.
    function automatic logic [7:0] f_bin2bcd2(input logic [6:0] v);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        if (rem >= 7'd80) begin tens[3] = 1'b1; rem = rem - 7'd80; end
        if (rem >= 7'd40) begin tens[2] = 1'b1; rem = rem - 7'd40; end
        if (rem >= 7'd20) begin tens[1] = 1'b1; rem = rem - 7'd20; end
        if (rem >= 7'd10) begin tens[0] = 1'b1; rem = rem - 7'd10; end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/contador_ad_mod_2dig_detector_flanco.sv
// Rising-edge detector: one-cycle tick when i_in goes 0->1 (combinational from the flop).
// Flop resets to 1 so a level already high at reset release produces no tick; no backpressure.
module contador_ad_mod_2dig_detector_flanco (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_tick
);

    logic r_in_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_in_q <= 1'b1;
        else          r_in_q <= i_in;
    end

    assign o_tick = i_in & ~r_in_q;

endmodule

// File: rtl/contador_ad_mod_2dig.sv
// Up/down range counter with wrap/saturate, sync load, carry/borrow/load_err pulses and BCD out.
// Edge at k -> count/pulses at k+1 -> digits at k+2; no backpressure, ticks never stall.
module contador_ad_mod_2dig
    import contador_ad_mod_2dig_pkg::*;
#(
    parameter int unsigned N       = 5,
    parameter int unsigned MOD_MIN = 0,
    parameter int unsigned MOD_MAX = MOD_HH,
    parameter bit          WRAP    = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en_up,
    input  logic         i_en_down,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    output logic [N-1:0] o_count,
    output logic         o_carry,
    output logic         o_borrow,
    output logic         o_load_err,
    output logic [3:0]   o_digit1,
    output logic [3:0]   o_digit0
);

    localparam logic [N-1:0] L_MIN     = N'(MOD_MIN);
    localparam logic [N-1:0] L_MAX     = N'(MOD_MAX);
    localparam logic [N-1:0] L_ONE     = N'(1);
    localparam logic [7:0]   L_RST_BCD = f_bin2bcd2(7'(MOD_MIN));

    logic         w_up_tick;
    logic         w_dn_tick;
    logic         w_count_legal;
    logic         w_load_legal;
    logic [N-1:0] w_count_nxt;
    logic         w_carry_nxt;
    logic         w_borrow_nxt;
    logic         w_load_err_nxt;
    logic [7:0]   w_bcd;

    logic [N-1:0] r_count;
    logic         r_carry;
    logic         r_borrow;
    logic         r_load_err;
    logic [3:0]   r_digit1;
    logic [3:0]   r_digit0;

    contador_ad_mod_2dig_detector_flanco u_det_up (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_in    (i_en_up),
        .o_tick  (w_up_tick)
    );

    contador_ad_mod_2dig_detector_flanco u_det_dn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_in    (i_en_down),
        .o_tick  (w_dn_tick)
    );

    assign w_count_legal = f_in_range(32'(r_count), MOD_MIN, MOD_MAX);
    assign w_load_legal  = f_in_range(32'(i_load_val), MOD_MIN, MOD_MAX);

    // An illegal count (upset) is pulled back to MOD_MIN by the next tick.
    always_comb begin
        w_count_nxt    = r_count;
        w_carry_nxt    = 1'b0;
        w_borrow_nxt   = 1'b0;
        w_load_err_nxt = 1'b0;
        if (i_load) begin
            if (w_load_legal) w_count_nxt    = i_load_val;
            else              w_load_err_nxt = 1'b1;
        end else if (w_up_tick && w_dn_tick) begin
            w_count_nxt = r_count;
        end else if (w_up_tick) begin
            if (!w_count_legal) begin
                w_count_nxt = L_MIN;
            end else if (r_count == L_MAX) begin
                if (WRAP) begin
                    w_count_nxt = L_MIN;
                    w_carry_nxt = 1'b1;
                end
            end else begin
                w_count_nxt = r_count + L_ONE;
            end
        end else if (w_dn_tick) begin
            if (!w_count_legal) begin
                w_count_nxt = L_MIN;
            end else if (r_count == L_MIN) begin
                if (WRAP) begin
                    w_count_nxt  = L_MAX;
                    w_borrow_nxt = 1'b1;
                end
            end else begin
                w_count_nxt = r_count - L_ONE;
            end
        end
    end

    assign w_bcd = w_count_legal ? f_bin2bcd2(7'(r_count)) : 8'h00;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count    <= L_MIN;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
            r_digit1   <= L_RST_BCD[7:4];
            r_digit0   <= L_RST_BCD[3:0];
        end else begin
            r_count    <= w_count_nxt;
            r_carry    <= w_carry_nxt;
            r_borrow   <= w_borrow_nxt;
            r_load_err <= w_load_err_nxt;
            r_digit1   <= w_bcd[7:4];
            r_digit0   <= w_bcd[3:0];
        end
    end

    assign o_count    = r_count;
    assign o_carry    = r_carry;
    assign o_borrow   = r_borrow;
    assign o_load_err = r_load_err;
    assign o_digit1   = r_digit1;
    assign o_digit0   = r_digit0;

endmodule

// File: tb/tb_contador_ad_mod_2dig.sv
// Directed bench: default 0..23 wrapping counter plus a 1..12 saturating instance.
module tb_contador_ad_mod_2dig;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       en_up = 1'b0, en_dn = 1'b0, load = 1'b0;
    logic [4:0] load_val = 5'd0;
    logic [4:0] count;
    logic       carry, borrow, load_err;
    logic [3:0] d1, d0;

    logic       en_up2 = 1'b0, en_dn2 = 1'b0, load2 = 1'b0;
    logic [4:0] load_val2 = 5'd0;
    logic [4:0] count2;
    logic       carry2, borrow2, load_err2;
    logic [3:0] d1_2, d0_2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    contador_ad_mod_2dig #(.N(5), .MOD_MIN(0), .MOD_MAX(23), .WRAP(1'b1)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_en_up(en_up), .i_en_down(en_dn),
        .i_load(load), .i_load_val(load_val), .o_count(count), .o_carry(carry),
        .o_borrow(borrow), .o_load_err(load_err), .o_digit1(d1), .o_digit0(d0)
    );

    contador_ad_mod_2dig #(.N(5), .MOD_MIN(1), .MOD_MAX(12), .WRAP(1'b0)) dut_sat (
        .i_clk(clk), .i_reset(rst_n), .i_en_up(en_up2), .i_en_down(en_dn2),
        .i_load(load2), .i_load_val(load_val2), .o_count(count2), .o_carry(carry2),
        .o_borrow(borrow2), .o_load_err(load_err2), .o_digit1(d1_2), .o_digit0(d0_2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if ({carry, borrow, load_err} !== 3'b000) begin failures++; $display("FAIL rst_pulses got=%b exp=000", {carry, borrow, load_err}); end
        checks++; if ({d1, d0} !== 8'h00) begin failures++; $display("FAIL rst_digits got=%h exp=00", {d1, d0}); end
        checks++; if (count2 !== 5'd1) begin failures++; $display("FAIL rst_sat_count got=%0d exp=1", count2); end
        checks++; if ({d1_2, d0_2} !== 8'h01) begin failures++; $display("FAIL rst_sat_digits got=%h exp=01", {d1_2, d0_2}); end
        #3 rst_n = 1'b1;
        step();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_release_count got=%0d exp=0", count); end
    endtask

    task automatic test_up_wrap();
        int exp_c;
        for (int i = 1; i <= 24; i++) begin
            exp_c = (i == 24) ? 0 : i;
            en_up = 1'b1;
            step();
            checks++; if (count !== 5'(exp_c)) begin failures++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count, exp_c); end
            checks++; if (carry !== (i == 24)) begin failures++; $display("FAIL up_carry[%0d] got=%b exp=%b", i, carry, (i == 24)); end
            en_up = 1'b0;
            step();
            checks++; if (carry !== 1'b0) begin failures++; $display("FAIL up_carry_clear[%0d] got=%b exp=0", i, carry); end
            checks++; if ({d1, d0} !== {4'(exp_c / 10), 4'(exp_c % 10)}) begin failures++; $display("FAIL up_digits[%0d] got=%h exp=%0d", i, {d1, d0}, exp_c); end
        end
    endtask

    task automatic test_down_wrap();
        en_dn = 1'b1;
        step();
        checks++; if (count !== 5'd23) begin failures++; $display("FAIL dn_count got=%0d exp=23", count); end
        checks++; if (borrow !== 1'b1) begin failures++; $display("FAIL dn_borrow got=%b exp=1", borrow); end
        checks++; if ({d1, d0} !== 8'h00) begin failures++; $display("FAIL dn_digits_lag got=%h exp=00", {d1, d0}); end
        en_dn = 1'b0;
        step();
        checks++; if (borrow !== 1'b0) begin failures++; $display("FAIL dn_borrow_clear got=%b exp=0", borrow); end
        checks++; if ({d1, d0} !== 8'h23) begin failures++; $display("FAIL dn_digits got=%h exp=23", {d1, d0}); end
        en_dn = 1'b1;
        step();
        checks++; if (count !== 5'd22 || borrow !== 1'b0) begin failures++; $display("FAIL dn_plain got=%0d/%b exp=22/0", count, borrow); end
        en_dn = 1'b0;
        step();
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 5'd17;
        step();
        checks++; if (count !== 5'd17 || load_err !== 1'b0) begin failures++; $display("FAIL load17 got=%0d/%b exp=17/0", count, load_err); end
        load = 1'b0;
        step();
        checks++; if ({d1, d0} !== 8'h17) begin failures++; $display("FAIL load17_digits got=%h exp=17", {d1, d0}); end
        load = 1'b1; load_val = 5'd30;
        step();
        checks++; if (count !== 5'd17 || load_err !== 1'b1) begin failures++; $display("FAIL load30 got=%0d/%b exp=17/1", count, load_err); end
        load = 1'b0;
        step();
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL load_err_clear got=%b exp=0", load_err); end
        load = 1'b1; load_val = 5'd23;
        step();
        checks++; if (count !== 5'd23) begin failures++; $display("FAIL load23 got=%0d exp=23", count); end
        load = 1'b1; load_val = 5'd5; en_up = 1'b1;
        step();
        checks++; if (count !== 5'd5 || carry !== 1'b0) begin failures++; $display("FAIL load_over_tick got=%0d/%b exp=5/0", count, carry); end
        load = 1'b0;
        step();
        checks++; if (count !== 5'd5) begin failures++; $display("FAIL tick_dropped got=%0d exp=5", count); end
        en_up = 1'b0;
        step();
    endtask

    task automatic test_simultaneous_and_held();
        en_up = 1'b1; en_dn = 1'b1;
        step();
        checks++; if (count !== 5'd5 || carry !== 1'b0 || borrow !== 1'b0) begin failures++; $display("FAIL both_ticks got=%0d/%b%b exp=5/00", count, carry, borrow); end
        en_up = 1'b0; en_dn = 1'b0;
        step();
        en_up = 1'b1;
        repeat (10) step();
        checks++; if (count !== 5'd6) begin failures++; $display("FAIL held_up got=%0d exp=6", count); end
        en_up = 1'b0;
        step();
    endtask

    task automatic test_saturate();
        en_dn2 = 1'b1;
        step();
        checks++; if (count2 !== 5'd1 || borrow2 !== 1'b0) begin failures++; $display("FAIL sat_min got=%0d/%b exp=1/0", count2, borrow2); end
        en_dn2 = 1'b0;
        load2 = 1'b1; load_val2 = 5'd0;
        step();
        checks++; if (count2 !== 5'd1 || load_err2 !== 1'b1) begin failures++; $display("FAIL sat_load0 got=%0d/%b exp=1/1", count2, load_err2); end
        load_val2 = 5'd12;
        step();
        checks++; if (count2 !== 5'd12 || load_err2 !== 1'b0) begin failures++; $display("FAIL sat_load12 got=%0d/%b exp=12/0", count2, load_err2); end
        load2 = 1'b0; en_up2 = 1'b1;
        step();
        checks++; if (count2 !== 5'd12 || carry2 !== 1'b0) begin failures++; $display("FAIL sat_max got=%0d/%b exp=12/0", count2, carry2); end
        en_up2 = 1'b0;
        step();
        checks++; if ({d1_2, d0_2} !== 8'h12) begin failures++; $display("FAIL sat_digits got=%h exp=12", {d1_2, d0_2}); end
        en_dn2 = 1'b1;
        step();
        checks++; if (count2 !== 5'd11) begin failures++; $display("FAIL sat_dn got=%0d exp=11", count2); end
        en_dn2 = 1'b0;
        step();
    endtask

    task automatic test_reset_cases();
        en_up = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL async_rst6 got=%0d exp=0", count); end
        step();
        #2 rst_n = 1'b1;
        repeat (3) step();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL held_through_rst got=%0d exp=0", count); end
        en_up = 1'b0;
        load = 1'b1; load_val = 5'd14;
        step();
        load = 1'b0;
        step();
        checks++; if (count !== 5'd14 || {d1, d0} !== 8'h14) begin failures++; $display("FAIL pre_rst14 got=%0d/%h exp=14/14", count, {d1, d0}); end
        en_up = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || {d1, d0} !== 8'h00) begin failures++; $display("FAIL midcount_rst got=%0d/%h exp=0/00", count, {d1, d0}); end
        checks++; if ({carry, borrow, load_err} !== 3'b000) begin failures++; $display("FAIL midcount_rst_pulses got=%b exp=000", {carry, borrow, load_err}); end
        step();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_hold got=%0d exp=0", count); end
        en_up = 1'b0;
        #2 rst_n = 1'b1;
        step();
        en_up = 1'b1;
        step();
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL post_rst_up got=%0d exp=1", count); end
        en_up = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_simultaneous_and_held();
        test_saturate();
        test_reset_cases();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
